// File: rtl/grf_dump_reader_pkg.sv
// Shared constants for the GRF dump reader: register file geometry
// (shared with the GRF itself) and the dump FSM state encodings.
package grf_dump_reader_pkg;

    // GRF geometry defaults
    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;

    // Dump FSM state encodings
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/grf_dump_reader.sv
// GRF dump reader: on start, walks every register index through one GRF
// read port (LOAD) and presents each (index, value) pair on a valid/ready
// stream (SEND). Snoops the GRF write port to flag registers that were
// rewritten after they had already been captured (sticky stale flag).
module grf_dump_reader
    import grf_dump_reader_pkg::*;
#(
    parameter int DATA_W    = GRF_DATA_W,
    parameter int ADDR_W    = GRF_ADDR_W,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              stale_o
);

    // idx carries one extra bit so the full register count is representable
    localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] IDX_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] FIRST_IDX = (SKIP_ZERO != 0) ? IDX_ONE : IDX_ZERO;
    localparam logic [ADDR_W:0] LAST_IDX  = {1'b0, {ADDR_W{1'b1}}};

    logic [ST_W-1:0]   state_q,    state_d;
    logic [ADDR_W:0]   idx_q,      idx_d;
    logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic [ADDR_W-1:0] out_idx_q,  out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              stale_q,    stale_d;

    logic              in_load;
    logic              in_send;
    logic              xfer;
    logic [ADDR_W:0]   wr_addr_ext;
    logic              wr_hits_captured;

    assign in_load     = (state_q == ST_LOAD);
    assign in_send     = (state_q == ST_SEND);
    assign xfer        = in_send && out_ready_i;
    assign wr_addr_ext = {1'b0, wr_addr_i};

    // A write is "late" if its target was already captured. In LOAD the
    // capture and the write share an edge, so equality only counts in SEND.
    // $0 is never written in a meaningful way, so it is excluded.
    always_comb begin
        wr_hits_captured = 1'b0;
        if (wr_en_i && (wr_addr_i != '0)) begin
            if (wr_addr_ext < idx_q)
                wr_hits_captured = 1'b1;
            else if (in_send && (wr_addr_ext == idx_q))
                wr_hits_captured = 1'b1;
        end
    end

    // Next-state logic: FSM, index walk, output holding register, stale flag
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_addr_d  = rd_addr_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        stale_d    = stale_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d   = FIRST_IDX;
                    stale_d = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // GRF read is combinational: capture the pair on this edge
                rd_addr_d  = idx_q[ADDR_W-1:0];
                out_idx_d  = idx_q[ADDR_W-1:0];
                out_data_d = rd_data_i;
                state_d    = ST_SEND;
                if (wr_hits_captured)
                    stale_d = 1'b1;
            end
            ST_SEND: begin
                if (wr_hits_captured)
                    stale_d = 1'b1;
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here; a new dump needs IDLE
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_ZERO;
            rd_addr_q  <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_addr_q  <= rd_addr_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            stale_q    <= stale_d;
        end
    end

    // rd_addr follows idx during LOAD so the GRF data is valid for capture,
    // and holds the last address used otherwise.
    assign rd_addr_o   = in_load ? idx_q[ADDR_W-1:0] : rd_addr_q;
    assign out_valid_o = in_send;
    assign out_idx_o   = out_idx_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = in_load || in_send;
    assign done_o      = (state_q == ST_DONE);
    assign stale_o     = stale_q;

endmodule
